scoreboard_unit: RTL and testbench

SCOREBOARD_UNIT -- requirements
Module: scoreboard_unit

---
 rtl/scoreboard_unit.sv | 81 ++++++++
 tb/tb_scoreboard_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_unit.sv
// Register scoreboard: tracks outstanding long-latency writes and stalls ID on RAW/WAW/capacity/flush.
// Latency: stall/issue_fire combinational, state +1 cycle; backpressure: stall holds ID, issue_fire marks acceptance.
module scoreboard_unit #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rs1,
    input  logic [4:0]  issue_rs2,
    input  logic        issue_uses_rs1,
    input  logic        issue_uses_rs2,
    input  logic [4:0]  issue_rd,
    input  logic        issue_reg_write,
    input  logic        issue_long,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        flush,
    output logic        stall,
    output logic        issue_fire,
    output logic [31:0] pending_mask,
    output logic [4:0]  busy_count,
    output logic        full,
    output logic        wb_err
);

    logic raw_rs1;
    logic raw_rs2;
    logic waw;
    logic cap;
    logic rd_nz;
    logic tracked;
    logic wb_hit;
    logic wb_bad;

    assign full  = (busy_count == 5'(MAX_OUTSTANDING));
    assign rd_nz = (issue_rd != 5'd0);

    // A source retiring this very cycle is forwarded from MEM/WB, so it is not a hazard.
    assign raw_rs1 = issue_uses_rs1 && (issue_rs1 != 5'd0) && pending_mask[issue_rs1]
                     && !(wb_valid && (wb_rd == issue_rs1));
    assign raw_rs2 = issue_uses_rs2 && (issue_rs2 != 5'd0) && pending_mask[issue_rs2]
                     && !(wb_valid && (wb_rd == issue_rs2));
    assign waw     = issue_reg_write && rd_nz && pending_mask[issue_rd];
    assign cap     = issue_long && issue_reg_write && rd_nz && full;

    assign stall      = issue_valid && (raw_rs1 || raw_rs2 || waw || cap || flush);
    assign issue_fire = issue_valid && !stall;

    // WAW blocks tracking a register that is already pending, so tracked and wb_hit never share a bit.
    assign tracked = issue_fire && issue_long && issue_reg_write && rd_nz;
    assign wb_hit  = wb_valid && (wb_rd != 5'd0) && pending_mask[wb_rd];
    assign wb_bad  = wb_valid && !wb_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_mask <= 32'd0;
            busy_count   <= 5'd0;
            wb_err       <= 1'b0;
        end else if (flush) begin
            pending_mask <= 32'd0;
            busy_count   <= 5'd0;
        end else begin
            if (tracked) begin
                pending_mask[issue_rd] <= 1'b1;
            end
            if (wb_hit) begin
                pending_mask[wb_rd] <= 1'b0;
            end
            case ({tracked, wb_hit})
                2'b10:   busy_count <= busy_count + 5'd1;
                2'b01:   busy_count <= busy_count - 5'd1;
                default: busy_count <= busy_count;
            endcase
            if (wb_bad) begin
                wb_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_scoreboard_unit.sv
// Bench for scoreboard_unit: directed scenarios plus random traffic against a list-based reference model.
module tb_scoreboard_unit;

    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic        issue_uses_rs1;
    logic        issue_uses_rs2;
    logic [4:0]  issue_rd;
    logic        issue_reg_write;
    logic        issue_long;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic        stall;
    logic        issue_fire;
    logic [31:0] pending_mask;
    logic [4:0]  busy_count;
    logic        full;
    logic        wb_err;

    scoreboard_unit #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_uses_rs1(issue_uses_rs1), .issue_uses_rs2(issue_uses_rs2),
        .issue_rd(issue_rd), .issue_reg_write(issue_reg_write), .issue_long(issue_long),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .stall(stall), .issue_fire(issue_fire), .pending_mask(pending_mask),
        .busy_count(busy_count), .full(full), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        fire;
        logic [31:0] mask;
        logic [4:0]  cnt;
        logic        full;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc_n = 0;

    // Reference model: the set of registers with an outstanding long write, plus the sticky error.
    int model_regs[$];
    bit model_err = 1'b0;

    function automatic bit has_reg(int r);
        foreach (model_regs[i]) if (model_regs[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_mask();
        logic [31:0] m = 32'd0;
        foreach (model_regs[i]) m[model_regs[i]] = 1'b1;
        return m;
    endfunction

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, req);
        end
    endtask

    task automatic step(input bit r, input bit fl, input bit iv,
                        input bit u1, input int rs1, input bit u2, input int rs2,
                        input bit rw, input bit lg, input int rd,
                        input bit wbv, input int wbrd);
        exp_t e;
        bit   raw1, raw2, waw, cap;
        @(posedge clk);
        #1;
        rst = r; flush = fl; issue_valid = iv;
        issue_uses_rs1 = u1; issue_rs1 = 5'(rs1);
        issue_uses_rs2 = u2; issue_rs2 = 5'(rs2);
        issue_reg_write = rw; issue_long = lg; issue_rd = 5'(rd);
        wb_valid = wbv; wb_rd = 5'(wbrd);
        cyc_n++;

        raw1 = u1 && rs1 != 0 && has_reg(rs1) && !(wbv && wbrd == rs1);
        raw2 = u2 && rs2 != 0 && has_reg(rs2) && !(wbv && wbrd == rs2);
        waw  = rw && rd != 0 && has_reg(rd);
        cap  = lg && rw && rd != 0 && model_regs.size() == MAXO;
        e.stall = iv && (raw1 || raw2 || waw || cap || fl);
        e.fire  = iv && !e.stall;
        e.mask  = model_mask();
        e.cnt   = 5'(model_regs.size());
        e.full  = (model_regs.size() == MAXO);
        e.err   = model_err;
        e.cyc   = cyc_n;
        exp_q.push_back(e);

        if (r) begin
            model_regs.delete();
            model_err = 1'b0;
        end else if (fl) begin
            model_regs.delete();
        end else begin
            if (wbv) begin
                if (wbrd != 0 && has_reg(wbrd)) begin
                    foreach (model_regs[i]) if (model_regs[i] == wbrd) begin
                        model_regs.delete(i);
                        break;
                    end
                end else begin
                    model_err = 1'b1;
                end
            end
            if (e.fire && lg && rw && rd != 0) model_regs.push_back(rd);
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: each negedge the DUT presents one cycle of outputs; pop its expectation and compare.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("stall",        e.cyc, {31'd0, stall},      {31'd0, e.stall});
                chk("issue_fire",   e.cyc, {31'd0, issue_fire}, {31'd0, e.fire});
                chk("pending_mask", e.cyc, pending_mask,        e.mask);
                chk("busy_count",   e.cyc, {27'd0, busy_count}, {27'd0, e.cnt});
                chk("full",         e.cyc, {31'd0, full},       {31'd0, e.full});
                chk("wb_err",       e.cyc, {31'd0, wb_err},     {31'd0, e.err});
            end
        end
    end

    initial begin
        int rd_r, wbrd_r;
        bit wbv_r;
        bit drained;
        rst = 1'b1; flush = 1'b0; issue_valid = 1'b0;
        issue_rs1 = '0; issue_rs2 = '0; issue_uses_rs1 = 1'b0; issue_uses_rs2 = 1'b0;
        issue_rd = '0; issue_reg_write = 1'b0; issue_long = 1'b0;
        wb_valid = 1'b0; wb_rd = '0;
        repeat (2) @(posedge clk);

        // load x5, then a consumer of x5 must stall
        step(0, 0, 1, 0, 0, 0, 0, 1, 1, 5, 0, 0);
        step(0, 0, 1, 1, 5, 0, 0, 1, 0, 8, 0, 0);
        // consumer of x5 via rs2 while x5 retires: forwarded, no stall
        step(0, 0, 1, 0, 0, 1, 5, 1, 0, 9, 1, 5);
        idle();
        // WAW on x5 holds even with same-cycle writeback of x5
        step(0, 0, 1, 0, 0, 0, 0, 1, 1, 5, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 1, 0, 5, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 1, 0, 5, 1, 5);
        step(0, 0, 1, 0, 0, 0, 0, 1, 0, 5, 0, 0);
        // x0 never hazards or tracks
        step(0, 0, 1, 1, 0, 1, 0, 1, 1, 0, 0, 0);
        // fill to capacity, then long rd=6 stalls and short rd=6 passes
        for (int r = 1; r <= 4; r++) step(0, 0, 1, 0, 0, 0, 0, 1, 1, r, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 1, 1, 6, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 1, 0, 6, 0, 0);
        // long rd=7 alongside writeback of x1 while full
        step(0, 0, 1, 0, 0, 0, 0, 1, 1, 7, 1, 1);
        // simultaneous track and retire at count 3
        step(0, 0, 1, 0, 0, 0, 0, 1, 1, 7, 1, 2);
        idle();
        // flush drops everything; a stale writeback then raises the sticky error
        step(0, 1, 1, 0, 0, 0, 0, 1, 1, 9, 1, 3);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
        idle(); idle();
        step(0, 0, 1, 0, 0, 0, 0, 1, 1, 10, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        // writeback to x0 is a protocol error
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 3000; n++) begin
            rd_r  = $urandom_range(0, 7);
            wbv_r = ($urandom_range(0, 9) < 4);
            if (model_regs.size() > 0 && $urandom_range(0, 7) != 0)
                wbrd_r = model_regs[$urandom_range(0, model_regs.size() - 1)];
            else
                wbrd_r = $urandom_range(0, 7);
            step($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                 $urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1, rd_r,
                 wbv_r, wbrd_r);
        end
        idle();

        drained = 1'b0;
        for (int w = 0; w < 10 && !drained; w++) begin
            @(posedge clk);
            drained = (exp_q.size() == 0);
        end
        total++;
        if (!drained) begin
            bad++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
